// File: rtl/mips_multicycle_control_pkg.sv
// mips_multicycle_control_pkg: opcodes, state encoding, mux codes and control bundle
// shared by the multi-cycle MIPS control FSM and its watchdog.
package mips_multicycle_control_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   localparam logic [1:0] ALUB_RT     = 2'b00;
   localparam logic [1:0] ALUB_FOUR   = 2'b01;
   localparam logic [1:0] ALUB_IMM    = 2'b10;
   localparam logic [1:0] ALUB_IMM_SH = 2'b11;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_FETCH   = 4'd1,
      S_DECODE  = 4'd2,
      S_MEMADR  = 4'd3,
      S_MEMRD   = 4'd4,
      S_MEMWB   = 4'd5,
      S_MEMWR   = 4'd6,
      S_EXECUTE = 4'd7,
      S_ALUWB   = 4'd8,
      S_BRANCH  = 4'd9,
      S_JUMP    = 4'd10,
      S_ADDIEX  = 4'd11,
      S_ADDIWB  = 4'd12
   } state_t;

   typedef struct packed {
      logic       pcwrite;
      logic       pcwritecond;
      logic       iord;
      logic       memread;
      logic       memwrite;
      logic       irwrite;
      logic       memtoreg;
      logic       regdst;
      logic       regwrite;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] aluop;
      logic [1:0] pcsrc;
   } ctrl_t;

   // States that wait on the memory handshake and are guarded by the watchdog
   function automatic logic is_mem_state(input state_t s);
      return s inside {S_FETCH, S_MEMRD, S_MEMWR};
   endfunction

endpackage

// File: rtl/mips_mem_watchdog.sv
// mips_mem_watchdog: counts consecutive mem_ready-low cycles in a memory state and
// flags expiry on the MEM_TIMEOUT-th one; MEM_TIMEOUT=0 disables it.
module mips_mem_watchdog #(
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic active_i,
   input  logic mem_ready_i,
   output logic expired_o
);

   localparam int unsigned W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam logic [W-1:0] CNT_MAX  = W'(MEM_TIMEOUT);
   localparam logic [W-1:0] CNT_LAST = W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

   logic [W-1:0] cnt_q, cnt_d;
   logic         stall;

   assign stall = active_i && !mem_ready_i;

   always_comb begin
      cnt_d = clr_i ? '0 : (stall && cnt_q != CNT_MAX) ? cnt_q + 1'b1 : cnt_q;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   // A ready in the expiry cycle completes the access normally
   assign expired_o = (MEM_TIMEOUT != 0) && stall && (cnt_q == CNT_LAST);

endmodule

// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control: main control FSM for the multi-cycle MIPS datapath,
// sequencing fetch/decode/execute/memory/writeback with a memory watchdog.
module mips_multicycle_control
   import mips_multicycle_control_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   output logic       pcwrite,
   output logic       pcwritecond,
   output logic       iord,
   output logic       memread,
   output logic       memwrite,
   output logic       irwrite,
   output logic       memtoreg,
   output logic       regdst,
   output logic       regwrite,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] aluop,
   output logic [1:0] pcsrc,
   output logic       illegal_op,
   output logic       mem_err,
   output logic [3:0] state
);

   state_t state_q, state_d;
   ctrl_t  c;
   logic   wd_expired;

   mips_mem_watchdog #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wd (
      .clk_i       (clk),
      .rst_i       (reset),
      .clr_i       (state_d != state_q),
      .active_i    (is_mem_state(state_q)),
      .mem_ready_i (mem_ready),
      .expired_o   (wd_expired)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      illegal_op = 1'b0;
      case (state_q)
         S_IDLE:    state_d = S_FETCH;
         S_FETCH:   state_d = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXECUTE;
               OP_BEQ:       state_d = S_BRANCH;
               OP_J:         state_d = S_JUMP;
               OP_ADDI:      state_d = S_ADDIEX;
               default: begin
                  state_d    = S_FETCH;
                  illegal_op = 1'b1;
               end
            endcase
         end
         S_MEMADR:  state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:   state_d = mem_ready ? S_MEMWB : S_MEMRD;
         S_MEMWR:   state_d = mem_ready ? S_FETCH : S_MEMWR;
         S_EXECUTE: state_d = S_ALUWB;
         S_ADDIEX:  state_d = S_ADDIWB;
         default:   state_d = S_FETCH;
      endcase
      // Abandon the instruction on a memory timeout; IDLE restarts with a fresh fetch
      if (wd_expired) state_d = S_IDLE;
   end

   always_comb begin
      c = '0;
      case (state_q)
         S_FETCH: begin
            c.memread = 1'b1;
            c.alusrcb = ALUB_FOUR;
            c.aluop   = ALUOP_ADD;
            c.pcsrc   = PCSRC_ALU;
            c.irwrite = mem_ready;
            c.pcwrite = mem_ready;
         end
         S_DECODE: begin
            c.alusrcb = ALUB_IMM_SH;
            c.aluop   = ALUOP_ADD;
         end
         S_MEMADR, S_ADDIEX: begin
            c.alusrca = 1'b1;
            c.alusrcb = ALUB_IMM;
            c.aluop   = ALUOP_ADD;
         end
         S_MEMRD: begin
            c.memread = 1'b1;
            c.iord    = 1'b1;
         end
         S_MEMWR: begin
            c.memwrite = 1'b1;
            c.iord     = 1'b1;
         end
         S_MEMWB: begin
            c.regwrite = 1'b1;
            c.memtoreg = 1'b1;
         end
         S_ADDIWB: c.regwrite = 1'b1;
         S_EXECUTE: begin
            c.alusrca = 1'b1;
            c.alusrcb = ALUB_RT;
            c.aluop   = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            c.regwrite = 1'b1;
            c.regdst   = 1'b1;
         end
         S_BRANCH: begin
            c.alusrca     = 1'b1;
            c.alusrcb     = ALUB_RT;
            c.aluop       = ALUOP_SUB;
            c.pcsrc       = PCSRC_ALUOUT;
            c.pcwritecond = 1'b1;
         end
         S_JUMP: begin
            c.pcwrite = 1'b1;
            c.pcsrc   = PCSRC_JUMP;
         end
         default: ;
      endcase
   end

   assign pcwrite     = c.pcwrite;
   assign pcwritecond = c.pcwritecond;
   assign iord        = c.iord;
   assign memread     = c.memread;
   assign memwrite    = c.memwrite;
   assign irwrite     = c.irwrite;
   assign memtoreg    = c.memtoreg;
   assign regdst      = c.regdst;
   assign regwrite    = c.regwrite;
   assign alusrca     = c.alusrca;
   assign alusrcb     = c.alusrcb;
   assign aluop       = c.aluop;
   assign pcsrc       = c.pcsrc;
   assign mem_err     = wd_expired;
   assign state       = state_q;

endmodule
